// File: rtl/wb_sram_ctrl.sv
// Wishbone classic slave turning single reads/writes into timed async-SRAM cycles.
// Request to ack is WAIT_STATES+3 cycles; all SRAM pins and Wishbone outputs are registered.
module wb_sram_ctrl #(
  parameter int ADDRESS_WIDTH      = 32,
  parameter int DATA_WIDTH         = 32,
  parameter int SRAM_ADDRESS_WIDTH = 19,
  parameter int WAIT_STATES        = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cycI,
  input  logic                          stbI,
  input  logic                          weI,
  output logic                          ackO,
  input  logic [ADDRESS_WIDTH-1:0]      adrI,
  input  logic [DATA_WIDTH-1:0]         datI,
  output logic [DATA_WIDTH-1:0]         datO,
  output logic [SRAM_ADDRESS_WIDTH-1:0] sramAdrO,
  input  logic [DATA_WIDTH-1:0]         sramDatI,
  output logic [DATA_WIDTH-1:0]         sramDatO,
  output logic                          sramDatOe,
  output logic                          sramCeN,
  output logic                          sramOeN,
  output logic                          sramWeN
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_ACK    = 2'd3
  } state_t;

  localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

  state_t                          state_q, state_d;
  logic [3:0]                      cnt_q, cnt_d;
  logic                            we_latch_q, we_latch_d;
  logic                            ack_q, ack_d;
  logic [DATA_WIDTH-1:0]           dat_o_q, dat_o_d;
  logic [SRAM_ADDRESS_WIDTH-1:0]   sram_adr_q, sram_adr_d;
  logic [DATA_WIDTH-1:0]           sram_dat_q, sram_dat_d;
  logic                            sram_dat_oe_q, sram_dat_oe_d;
  logic                            sram_ce_n_q, sram_ce_n_d;
  logic                            sram_oe_n_q, sram_oe_n_d;
  logic                            sram_we_n_q, sram_we_n_d;

  // Upper address bits select nothing on the SRAM side.
  generate
    if (ADDRESS_WIDTH > SRAM_ADDRESS_WIDTH) begin : g_adr_hi
      logic unused_adr_hi;
      assign unused_adr_hi = ^adrI[ADDRESS_WIDTH-1:SRAM_ADDRESS_WIDTH];
    end
  endgenerate

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    we_latch_d    = we_latch_q;
    ack_d         = 1'b0;
    dat_o_d       = dat_o_q;
    sram_adr_d    = sram_adr_q;
    sram_dat_d    = sram_dat_q;
    sram_dat_oe_d = sram_dat_oe_q;
    sram_ce_n_d   = sram_ce_n_q;
    sram_oe_n_d   = sram_oe_n_q;
    sram_we_n_d   = sram_we_n_q;

    case (state_q)
      ST_IDLE: begin
        sram_ce_n_d   = 1'b1;
        sram_oe_n_d   = 1'b1;
        sram_we_n_d   = 1'b1;
        sram_dat_oe_d = 1'b0;
        if (cycI && stbI) begin
          state_d       = ST_SETUP;
          sram_adr_d    = adrI[SRAM_ADDRESS_WIDTH-1:0];
          sram_dat_d    = datI;
          we_latch_d    = weI;
          sram_ce_n_d   = 1'b0;
          sram_dat_oe_d = weI;
          sram_oe_n_d   = weI;
        end
      end

      ST_SETUP: begin
        if (!cycI) begin
          state_d       = ST_IDLE;
          sram_ce_n_d   = 1'b1;
          sram_oe_n_d   = 1'b1;
          sram_we_n_d   = 1'b1;
          sram_dat_oe_d = 1'b0;
        end else begin
          state_d     = ST_ACCESS;
          cnt_d       = WS_LOAD;
          sram_we_n_d = !we_latch_q;
        end
      end

      ST_ACCESS: begin
        if (!cycI) begin
          state_d       = ST_IDLE;
          sram_ce_n_d   = 1'b1;
          sram_oe_n_d   = 1'b1;
          sram_we_n_d   = 1'b1;
          sram_dat_oe_d = 1'b0;
        end else if (cnt_q == 4'd0) begin
          // Capture on the same edge that releases OE; pad data is still valid.
          state_d     = ST_ACK;
          ack_d       = 1'b1;
          sram_we_n_d = 1'b1;
          sram_oe_n_d = 1'b1;
          if (!we_latch_q) begin
            dat_o_d = sramDatI;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_ACK: begin
        state_d       = ST_IDLE;
        sram_ce_n_d   = 1'b1;
        sram_oe_n_d   = 1'b1;
        sram_we_n_d   = 1'b1;
        sram_dat_oe_d = 1'b0;
      end

      default: begin
        state_d       = ST_IDLE;
        sram_ce_n_d   = 1'b1;
        sram_oe_n_d   = 1'b1;
        sram_we_n_d   = 1'b1;
        sram_dat_oe_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 4'd0;
      we_latch_q    <= 1'b0;
      ack_q         <= 1'b0;
      dat_o_q       <= '0;
      sram_adr_q    <= '0;
      sram_dat_q    <= '0;
      sram_dat_oe_q <= 1'b0;
      sram_ce_n_q   <= 1'b1;
      sram_oe_n_q   <= 1'b1;
      sram_we_n_q   <= 1'b1;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      we_latch_q    <= we_latch_d;
      ack_q         <= ack_d;
      dat_o_q       <= dat_o_d;
      sram_adr_q    <= sram_adr_d;
      sram_dat_q    <= sram_dat_d;
      sram_dat_oe_q <= sram_dat_oe_d;
      sram_ce_n_q   <= sram_ce_n_d;
      sram_oe_n_q   <= sram_oe_n_d;
      sram_we_n_q   <= sram_we_n_d;
    end
  end

  assign ackO      = ack_q;
  assign datO      = dat_o_q;
  assign sramAdrO  = sram_adr_q;
  assign sramDatO  = sram_dat_q;
  assign sramDatOe = sram_dat_oe_q;
  assign sramCeN   = sram_ce_n_q;
  assign sramOeN   = sram_oe_n_q;
  assign sramWeN   = sram_we_n_q;

endmodule
